board_renderer: RTL and testbench



---
 rtl/board_pkg.sv | 29 ++
 rtl/board_renderer_pix.sv | 96 +++++++++
 rtl/board_renderer.sv | 112 +++++++++++
 tb/tb_board_renderer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared constants, colour table and state encoding for the board renderer.
package board_pkg;

    localparam int DEF_COLS       = 10;
    localparam int DEF_ROWS       = 20;
    localparam int DEF_CELL_SHIFT = 4;
    localparam int DEF_BOARD_X0   = 220;
    localparam int DEF_BOARD_Y0   = 40;
    localparam int DEF_BORDER_W   = 4;

    typedef logic [2:0]  cell_t;
    typedef logic [23:0] rgb_t;

    // Entry 0 sits in the least significant slot, so PALETTE[code] maps directly.
    localparam rgb_t [7:0] PALETTE = {
        24'hFF8000, 24'h0000FF, 24'hFF0000, 24'h00FF00,
        24'h800080, 24'hFFFF00, 24'h00FFFF, 24'h000000
    };

    localparam rgb_t GRID_RGB   = 24'h404040;
    localparam rgb_t BORDER_RGB = 24'hFFFFFF;
    localparam rgb_t BG_RGB     = 24'h000000;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

endpackage

// File: rtl/board_renderer_pix.sv
// Two-stage pixel pipeline: classify the coordinate and fetch the cell, then pick a colour.
module board_pix_pipe
    import board_pkg::*;
#(
    parameter int COLS       = DEF_COLS,
    parameter int ROWS       = DEF_ROWS,
    parameter int CELL_SHIFT = DEF_CELL_SHIFT,
    parameter int BOARD_X0   = DEF_BOARD_X0,
    parameter int BOARD_Y0   = DEF_BOARD_Y0,
    parameter int BORDER_W   = DEF_BORDER_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             pix_x_i,
    input  logic [9:0]             pix_y_i,
    input  logic                   pix_de_i,
    input  cell_t [COLS*ROWS-1:0]  cells_i,
    output logic [23:0]            rgb_o,
    output logic                   rgb_de_o
);

    localparam int CELLS = COLS * ROWS;
    localparam int IDXW  = $clog2(CELLS);

    localparam logic signed [10:0] X0 = 11'(BOARD_X0);
    localparam logic signed [10:0] Y0 = 11'(BOARD_Y0);
    localparam logic signed [10:0] W  = 11'(COLS << CELL_SHIFT);
    localparam logic signed [10:0] H  = 11'(ROWS << CELL_SHIFT);
    localparam logic signed [10:0] BW = 11'(BORDER_W);

    logic signed [10:0] dx, dy;
    logic [10:0]        col, row;
    logic [IDXW-1:0]    idx;
    logic               in_board, in_border, grid;
    cell_t              code;

    logic  de1_q, board1_q, border1_q, grid1_q;
    cell_t code1_q;
    rgb_t  rgb_d, rgb_q;
    logic  de2_q;

    // Cell lookup only happens inside the board, keeping the array index in range.
    always_comb begin
        dx        = $signed({1'b0, pix_x_i}) - X0;
        dy        = $signed({1'b0, pix_y_i}) - Y0;
        in_board  = !dx[10] && (dx < W) && !dy[10] && (dy < H);
        in_border = (dx >= -BW) && (dx < W + BW) && (dy >= -BW) && (dy < H + BW) && !in_board;
        grid      = (dx[CELL_SHIFT-1:0] == '0) || (dy[CELL_SHIFT-1:0] == '0);
        col       = $unsigned(dx) >> CELL_SHIFT;
        row       = $unsigned(dy) >> CELL_SHIFT;
        idx       = '0;
        code      = '0;
        if (in_board) begin
            idx  = IDXW'(row * 11'(COLS) + col);
            code = cells_i[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de1_q     <= 1'b0;
            board1_q  <= 1'b0;
            border1_q <= 1'b0;
            grid1_q   <= 1'b0;
            code1_q   <= '0;
        end else begin
            de1_q     <= pix_de_i;
            board1_q  <= in_board;
            border1_q <= in_border;
            grid1_q   <= grid;
            code1_q   <= code;
        end
    end

    always_comb begin
        rgb_d = BG_RGB;
        if (!de1_q)                   rgb_d = '0;
        else if (border1_q)           rgb_d = BORDER_RGB;
        else if (board1_q && grid1_q) rgb_d = GRID_RGB;
        else if (board1_q)            rgb_d = PALETTE[code1_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
            de2_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            de2_q <= de1_q;
        end
    end

    assign rgb_o    = rgb_q;
    assign rgb_de_o = de2_q;

endmodule

// File: rtl/board_renderer.sv
// Board storage, write port and clear sequencer feeding the pixel pipeline.
module board_renderer
    import board_pkg::*;
#(
    parameter int COLS       = DEF_COLS,
    parameter int ROWS       = DEF_ROWS,
    parameter int CELL_SHIFT = DEF_CELL_SHIFT,
    parameter int BOARD_X0   = DEF_BOARD_X0,
    parameter int BOARD_Y0   = DEF_BOARD_Y0,
    parameter int BORDER_W   = DEF_BORDER_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pix_de,
    output logic [23:0] rgb,
    output logic        rgb_de,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_col,
    input  logic [4:0]  wr_row,
    input  logic [2:0]  wr_color,
    output logic        wr_err,
    input  logic        clr_req,
    output logic        busy
);

    localparam int CELLS = COLS * ROWS;
    localparam int IDXW  = $clog2(CELLS);

    state_t              state_q, state_d;
    logic [IDXW-1:0]     clr_cnt_q, clr_cnt_d;
    cell_t [CELLS-1:0]   cells_q;
    logic                wr_err_q, wr_err_d;
    logic                do_write, wr_in_range;
    logic [IDXW-1:0]     wr_idx;

    // A write and a clear request in the same IDLE cycle both take effect: write now, clear next.
    always_comb begin
        wr_in_range = (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);
        wr_idx      = IDXW'(int'(wr_row) * COLS + int'(wr_col));
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        wr_ready    = 1'b0;
        busy        = 1'b0;
        do_write    = 1'b0;
        wr_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    if (wr_in_range) do_write = 1'b1;
                    else             wr_err_d = 1'b1;
                end
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                busy      = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == IDXW'(CELLS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_err_q  <= wr_err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cells_q <= '0;
        end else if (state_q == CLEAR) begin
            cells_q[clr_cnt_q] <= '0;
        end else if (do_write) begin
            cells_q[wr_idx] <= wr_color;
        end
    end

    assign wr_err = wr_err_q;

    board_pix_pipe #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .CELL_SHIFT (CELL_SHIFT),
        .BOARD_X0   (BOARD_X0),
        .BOARD_Y0   (BOARD_Y0),
        .BORDER_W   (BORDER_W)
    ) u_pix (
        .clk      (clk),
        .rst      (rst),
        .pix_x_i  (pix_x),
        .pix_y_i  (pix_y),
        .pix_de_i (pix_de),
        .cells_i  (cells_q),
        .rgb_o    (rgb),
        .rgb_de_o (rgb_de)
    );

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer with a per-cycle reference model of the board and pixel colours.
module tb_board_renderer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  pix_x = '0;
   logic [9:0]  pix_y = '0;
   logic        pix_de = 1'b0;
   logic [23:0] rgb;
   logic        rgb_de;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [3:0]  wr_col = '0;
   logic [4:0]  wr_row = '0;
   logic [2:0]  wr_color = '0;
   logic        wr_err;
   logic        clr_req = 1'b0;
   logic        busy;

   int passCount = 0;
   int checkCount = 0;

   always #5 clk = ~clk;

   board_renderer dut (
      .clk      (clk),
      .rst      (rst),
      .pix_x    (pix_x),
      .pix_y    (pix_y),
      .pix_de   (pix_de),
      .rgb      (rgb),
      .rgb_de   (rgb_de),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_col   (wr_col),
      .wr_row   (wr_row),
      .wr_color (wr_color),
      .wr_err   (wr_err),
      .clr_req  (clr_req),
      .busy     (busy)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
   endtask

   // Reference model: board contents as a plain column/row grid, colours from the geometry rules.
   int          mCells [10][20];
   bit          mClearing = 1'b0;
   int          mClrIdx = 0;
   logic [23:0] expRgb1 = '0, expRgb2 = '0;
   logic        expDe1 = 1'b0, expDe2 = 1'b0;
   logic        expErr = 1'b0;
   bit          modelReady = 1'b0;

   function automatic logic [23:0] paletteOf(input int c);
      case (c)
         1: return 24'h00FFFF;
         2: return 24'hFFFF00;
         3: return 24'h800080;
         4: return 24'h00FF00;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         7: return 24'hFF8000;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic logic [23:0] pixelRgb(input int x, input int y, input bit de);
      int dx = x - 220;
      int dy = y - 40;
      bit inB = (dx >= 0) && (dx < 160) && (dy >= 0) && (dy < 320);
      bit inF = (dx >= -4) && (dx < 164) && (dy >= -4) && (dy < 324) && !inB;
      if (!de) return 24'h000000;
      if (inF) return 24'hFFFFFF;
      if (inB && ((dx % 16 == 0) || (dy % 16 == 0))) return 24'h404040;
      if (inB) return paletteOf(mCells[dx / 16][dy / 16]);
      return 24'h000000;
   endfunction

   // Model advances on each clock edge; colour is computed before this edge's board update.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < 10; c++)
            for (int r = 0; r < 20; r++) mCells[c][r] = 0;
         mClearing = 1'b0;
         mClrIdx = 0;
         expRgb1 = '0;
         expRgb2 = '0;
         expDe1 = 1'b0;
         expDe2 = 1'b0;
         expErr = 1'b0;
      end else begin
         expRgb2 = expRgb1;
         expDe2 = expDe1;
         expRgb1 = pixelRgb(int'(pix_x), int'(pix_y), pix_de);
         expDe1 = pix_de;
         expErr = 1'b0;
         if (!mClearing) begin
            if (wr_valid) begin
               if (int'(wr_col) < 10 && int'(wr_row) < 20) mCells[wr_col][wr_row] = int'(wr_color);
               else expErr = 1'b1;
            end
            if (clr_req) begin
               mClearing = 1'b1;
               mClrIdx = 0;
            end
         end else begin
            mCells[mClrIdx % 10][mClrIdx / 10] = 0;
            mClrIdx++;
            if (mClrIdx == 200) mClearing = 1'b0;
         end
      end
      modelReady = 1'b1;
   end

   // Every falling edge compares all outputs against the model.
   always @(negedge clk) begin
      if (modelReady) begin
         checkOutput("rgb", rgb, expRgb2);
         checkOutput("rgb_de", rgb_de, expDe2);
         checkOutput("busy", busy, mClearing);
         checkOutput("wr_ready", wr_ready, !mClearing);
         checkOutput("wr_err", wr_err, expErr);
      end
   end

   task automatic applyStimulus(input int x, input int y, input bit de);
      @(negedge clk);
      pix_x = 10'(x);
      pix_y = 10'(y);
      pix_de = de;
   endtask

   task automatic presentAndCheck(input string name, input int x, input int y, input logic [23:0] exp);
      applyStimulus(x, y, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput(name, rgb, exp);
   endtask

   task automatic writeCell(input int c, input int r, input int color);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_col = 4'(c);
      wr_row = 5'(r);
      wr_color = 3'(color);
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic sweepRow(input int y, input int x0, input int x1);
      for (int x = x0; x <= x1; x++) applyStimulus(x, y, (x % 23) != 0);
   endtask

   task automatic sweepCells();
      for (int r = 0; r < 20; r++)
         for (int c = 0; c < 10; c++) applyStimulus(220 + c * 16 + 8, 40 + r * 16 + 8, 1'b1);
   endtask

   int sweepYs [15] = '{34, 35, 36, 37, 38, 39, 40, 41, 48, 56, 100, 359, 360, 363, 364};
   int n;

   initial begin
      // Reset state
      @(negedge clk);
      checkOutput("reset_rgb", rgb, 24'h000000);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_wr_ready", wr_ready, 1'b1);
      checkOutput("reset_wr_err", wr_err, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Empty board sweep across edges and border
      foreach (sweepYs[i]) sweepRow(sweepYs[i], 210, 390);
      presentAndCheck("border_left", 218, 100, 24'hFFFFFF);
      presentAndCheck("background", 100, 100, 24'h000000);
      applyStimulus(230, 100, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("de_low_rgb", rgb, 24'h000000);
      checkOutput("de_low_rgb_de", rgb_de, 1'b0);

      // Single cell write and colour lookup
      writeCell(0, 0, 5);
      presentAndCheck("cell00_red", 221, 41, 24'hFF0000);
      presentAndCheck("grid_line", 220, 41, 24'h404040);
      presentAndCheck("border_right", 380, 41, 24'hFFFFFF);

      // Out-of-range write
      @(negedge clk);
      wr_valid = 1'b1;
      wr_col = 4'd10;
      wr_row = 5'd3;
      wr_color = 3'd2;
      checkOutput("oob_wr_ready", wr_ready, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("oob_err_pulse", wr_err, 1'b1);
      @(negedge clk);
      wr_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("oob_err_low", wr_err, 1'b0);
      sweepRow(96, 215, 385);
      sweepRow(112, 215, 385);
      presentAndCheck("oob_no_alias", 225, 109, 24'h000000);

      // Clear sequence with a held write
      writeCell(1, 1, 3);
      writeCell(5, 10, 4);
      writeCell(9, 19, 7);
      presentAndCheck("cell919_orange", 369, 349, 24'hFF8000);
      @(negedge clk);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      wr_valid = 1'b1;
      wr_col = 4'd4;
      wr_row = 5'd4;
      wr_color = 3'd6;
      n = 0;
      while (busy && n < 400) begin
         n++;
         if (n == 100) clr_req = 1'b1;
         if (n == 101) clr_req = 1'b0;
         @(negedge clk);
      end
      checkOutput("clear_length", n, 200);
      checkOutput("ready_after_clear", wr_ready, 1'b1);
      @(negedge clk);
      wr_valid = 1'b0;
      sweepCells();
      presentAndCheck("cleared_cell", 369, 349, 24'h000000);
      presentAndCheck("held_write_blue", 289, 109, 24'h0000FF);

      // Read/write collision on one cell
      @(negedge clk);
      wr_valid = 1'b1;
      wr_col = 4'd2;
      wr_row = 5'd2;
      wr_color = 3'd1;
      pix_x = 10'd253;
      pix_y = 10'd73;
      pix_de = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wr_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("collision_old", rgb, 24'h000000);
      @(posedge clk);
      #1;
      checkOutput("collision_new", rgb, 24'h00FFFF);

      // Reset in the middle of a clear
      writeCell(9, 19, 7);
      applyStimulus(369, 349, 1'b1);
      @(negedge clk);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      repeat (49) @(negedge clk);
      checkOutput("pre_reset_busy", busy, 1'b1);
      checkOutput("pre_reset_rgb", rgb, 24'hFF8000);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mid_reset_rgb", rgb, 24'h000000);
      checkOutput("mid_reset_rgb_de", rgb_de, 1'b0);
      checkOutput("mid_reset_busy", busy, 1'b0);
      checkOutput("mid_reset_wr_ready", wr_ready, 1'b1);
      checkOutput("mid_reset_wr_err", wr_err, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      sweepCells();
      presentAndCheck("post_reset_cell", 369, 349, 24'h000000);

      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
